// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-queue signal bundle shared by the scanner and its consumer.
// The slave modport is the scanner side; master is the board/driver side.
interface keypad_scanner_if;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic       key_available;
    logic [3:0] key;
    logic       pull_key;
    logic       overflow;
    logic       clear_overflow;

    modport master (
        input  row_n,
        input  key_available,
        input  key,
        input  overflow,
        output col_n,
        output pull_key,
        output clear_overflow
    );

    modport slave (
        output row_n,
        output key_available,
        output key,
        output overflow,
        input  col_n,
        input  pull_key,
        input  clear_overflow
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: row drive, column synchronizer, press/release debounce and a
// show-ahead FIFO of key codes with a sticky overflow flag.
module keypad_scanner #(
    parameter int unsigned SETTLE   = 4,
    parameter int unsigned DEBOUNCE = 16,
    parameter int unsigned DEPTH    = 8
) (
    input logic             working_clock,
    input logic             reset,
    keypad_scanner_if.slave bus
);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned PW  = AW + 1;
    localparam int unsigned SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned DCW = $clog2(DEBOUNCE);

    localparam logic [SCW-1:0] SettleLast = SCW'(SETTLE - 1);
    localparam logic [DCW-1:0] DebLast    = DCW'(DEBOUNCE - 1);

    localparam logic [1:0] StScan     = 2'd0;
    localparam logic [1:0] StDebounce = 2'd1;
    localparam logic [1:0] StHeld     = 2'd2;

    logic [3:0]     meta_q, cs_q;
    logic [1:0]     state_q, state_d;
    logic [1:0]     row_q, row_d;
    logic [SCW-1:0] settle_q, settle_d;
    logic [DCW-1:0] deb_q, deb_d;
    logic [3:0]     pat_q, pat_d;
    logic [3:0]     code_q, code_d;
    logic           push;

    logic [3:0]     low;
    logic           one_low;
    logic [1:0]     col_idx;

    logic [3:0]     mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic           empty, full, pop, do_push, ovf_set;
    logic           overflow_q, overflow_d;

    // col_n is asynchronous; everything downstream only looks at cs_q.
    always_ff @(posedge working_clock or negedge reset) begin
        if (!reset) begin
            meta_q <= 4'hF;
            cs_q   <= 4'hF;
        end else begin
            meta_q <= bus.col_n;
            cs_q   <= meta_q;
        end
    end

    assign low     = ~cs_q;
    assign one_low = (low != 4'h0) && ((low & (low - 4'd1)) == 4'h0);

    always_comb begin
        col_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (low[i]) begin
                col_idx = 2'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        settle_d = settle_q;
        deb_d    = deb_q;
        pat_d    = pat_q;
        code_d   = code_q;
        push     = 1'b0;
        case (state_q)
            StScan: begin
                if (settle_q == SettleLast) begin
                    settle_d = '0;
                    if (one_low) begin
                        pat_d   = cs_q;
                        code_d  = {row_q, col_idx};
                        deb_d   = '0;
                        state_d = StDebounce;
                    end else begin
                        // Idle row or ghosted multi-key: move on.
                        row_d = row_q + 2'd1;
                    end
                end else begin
                    settle_d = settle_q + SCW'(1);
                end
            end
            StDebounce: begin
                if (cs_q == pat_q) begin
                    if (deb_q == DebLast) begin
                        push    = 1'b1;
                        deb_d   = '0;
                        state_d = StHeld;
                    end else begin
                        deb_d = deb_q + DCW'(1);
                    end
                end else begin
                    deb_d    = '0;
                    row_d    = row_q + 2'd1;
                    settle_d = '0;
                    state_d  = StScan;
                end
            end
            StHeld: begin
                // Row stays driven until the key has been released long enough.
                if (cs_q == 4'hF) begin
                    if (deb_q == DebLast) begin
                        deb_d    = '0;
                        row_d    = row_q + 2'd1;
                        settle_d = '0;
                        state_d  = StScan;
                    end else begin
                        deb_d = deb_q + DCW'(1);
                    end
                end else begin
                    deb_d = '0;
                end
            end
            default: begin
                state_d  = StScan;
                settle_d = '0;
                deb_d    = '0;
            end
        endcase
    end

    always_ff @(posedge working_clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StScan;
            row_q    <= 2'd0;
            settle_q <= '0;
            deb_q    <= '0;
            pat_q    <= 4'hF;
            code_q   <= 4'h0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            settle_q <= settle_d;
            deb_q    <= deb_d;
            pat_q    <= pat_d;
            code_q   <= code_d;
        end
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = bus.pull_key && !empty;
    // A pop frees the slot in the same edge, so a full FIFO still accepts the push.
    assign do_push = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    always_comb begin
        overflow_d = overflow_q;
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (bus.clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge working_clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 4'h0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= code_q;
        end
    end

    always_ff @(posedge working_clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            overflow_q <= overflow_d;
        end
    end

    assign bus.row_n         = ~(4'b0001 << row_q);
    assign bus.key           = mem_q[rd_ptr_q[AW-1:0]];
    assign bus.key_available = !empty;
    assign bus.overflow      = overflow_q;
endmodule
